// File: rtl/segre_store_buffer.sv
// segre_store_buffer: in-order store buffer between the MEM stage and the dcache.
// Stores are drained oldest-first, and younger loads are checked against pending stores.
`timescale 1ns/1ps
module segre_store_buffer #(
  parameter int unsigned NUM_ENTRIES = 32'd4,
  parameter int unsigned PTR_BITS    = 32'd2,
  parameter int unsigned ADDR_SIZE   = 32'd32,
  parameter int unsigned WORD_SIZE   = 32'd32
) (
  input  logic                 clk_i,
  input  logic                 rsn_i,
  input  logic                 push_i,
  input  logic [ADDR_SIZE-1:0] push_addr_i,
  input  logic [WORD_SIZE-1:0] push_data_i,
  input  logic [1:0]           push_type_i,
  output logic                 full_o,
  output logic                 empty_o,
  input  logic                 ld_lookup_i,
  input  logic [ADDR_SIZE-1:0] ld_addr_i,
  input  logic [1:0]           ld_type_i,
  output logic                 ld_hit_o,
  output logic [WORD_SIZE-1:0] ld_data_o,
  output logic                 ld_conflict_o,
  output logic                 drain_valid_o,
  output logic [ADDR_SIZE-1:0] drain_addr_o,
  output logic [WORD_SIZE-1:0] drain_data_o,
  output logic [1:0]           drain_type_o,
  input  logic                 drain_ready_i
);

  localparam logic [1:0] TYPE_BYTE = 2'b00;

  logic [ADDR_SIZE-1:0] r_addr [NUM_ENTRIES];
  logic [WORD_SIZE-1:0] r_data [NUM_ENTRIES];
  logic [1:0]           r_type [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] r_valid;
  logic [PTR_BITS-1:0]  r_head;
  logic [PTR_BITS-1:0]  r_tail;
  logic [PTR_BITS:0]    r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic                 w_ld_hit;
  logic                 w_ld_conflict;
  logic [WORD_SIZE-1:0] w_ld_data;

  assign w_full  = (r_count == (PTR_BITS+1)'(NUM_ENTRIES));
  assign w_empty = (r_count == '0);
  // Full is taken from registered state only, so a drain never frees a slot for the same cycle's push.
  assign w_push  = push_i && !w_full;
  assign w_pop   = !w_empty && drain_ready_i;

  assign full_o  = w_full;
  assign empty_o = w_empty;

  // Pointer, occupancy and valid-bit state.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PTR_BITS'(1);
      end
      if (w_push) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + PTR_BITS'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_BITS+1)'(1);
        2'b01:   r_count <= r_count - (PTR_BITS+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry payload; only qualified by valid, so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_addr[r_tail] <= push_addr_i;
      r_data[r_tail] <= push_data_i;
      r_type[r_tail] <= push_type_i;
    end
  end

  // Drain port shows the head entry, forced to zero while empty.
  always_comb begin
    drain_valid_o = 1'b0;
    drain_addr_o  = '0;
    drain_data_o  = '0;
    drain_type_o  = TYPE_BYTE;
    if (!w_empty) begin
      drain_valid_o = 1'b1;
      drain_addr_o  = r_addr[r_head];
      drain_data_o  = r_data[r_head];
      drain_type_o  = r_type[r_head];
    end else begin
      drain_valid_o = 1'b0;
    end
  end

  // Load lookup: walk backwards from tail-1 so the youngest overlapping store decides.
  always_comb begin
    logic                found;
    logic [PTR_BITS-1:0] idx;
    found         = 1'b0;
    idx           = '0;
    w_ld_hit      = 1'b0;
    w_ld_conflict = 1'b0;
    w_ld_data     = '0;
    if (ld_lookup_i) begin
      for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
        idx = r_tail - PTR_BITS'(i + 1);
        if (!found && r_valid[idx] &&
            (r_addr[idx][ADDR_SIZE-1:2] == ld_addr_i[ADDR_SIZE-1:2])) begin
          found = 1'b1;
          if ((r_addr[idx] == ld_addr_i) && (r_type[idx] == ld_type_i)) begin
            w_ld_hit  = 1'b1;
            w_ld_data = r_data[idx];
          end else begin
            w_ld_conflict = 1'b1;
          end
        end else begin
          found = found;
        end
      end
    end else begin
      w_ld_hit      = 1'b0;
      w_ld_conflict = 1'b0;
    end
  end

  assign ld_hit_o      = w_ld_hit;
  assign ld_conflict_o = w_ld_conflict;
  assign ld_data_o     = w_ld_data;

endmodule

// File: tb/tb_segre_store_buffer.sv
// Directed self-checking bench for segre_store_buffer.
`timescale 1ns/1ps
module tb_segre_store_buffer;

  localparam logic [1:0] T_BYTE = 2'b00;
  localparam logic [1:0] T_HALF = 2'b01;
  localparam logic [1:0] T_WORD = 2'b10;

  logic        clk_i = 1'b0;
  logic        rsn_i;
  logic        push_i;
  logic [31:0] push_addr_i;
  logic [31:0] push_data_i;
  logic [1:0]  push_type_i;
  logic        full_o;
  logic        empty_o;
  logic        ld_lookup_i;
  logic [31:0] ld_addr_i;
  logic [1:0]  ld_type_i;
  logic        ld_hit_o;
  logic [31:0] ld_data_o;
  logic        ld_conflict_o;
  logic        drain_valid_o;
  logic [31:0] drain_addr_o;
  logic [31:0] drain_data_o;
  logic [1:0]  drain_type_o;
  logic        drain_ready_i;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  segre_store_buffer dut (
    .clk_i(clk_i), .rsn_i(rsn_i),
    .push_i(push_i), .push_addr_i(push_addr_i), .push_data_i(push_data_i), .push_type_i(push_type_i),
    .full_o(full_o), .empty_o(empty_o),
    .ld_lookup_i(ld_lookup_i), .ld_addr_i(ld_addr_i), .ld_type_i(ld_type_i),
    .ld_hit_o(ld_hit_o), .ld_data_o(ld_data_o), .ld_conflict_o(ld_conflict_o),
    .drain_valid_o(drain_valid_o), .drain_addr_o(drain_addr_o), .drain_data_o(drain_data_o),
    .drain_type_o(drain_type_o), .drain_ready_i(drain_ready_i)
  );

  // One-cycle push: driven after a falling edge, released after the following rising edge.
  task automatic push_one(input logic [31:0] a, input logic [31:0] d, input logic [1:0] t);
    @(negedge clk_i);
    push_i = 1'b1; push_addr_i = a; push_data_i = d; push_type_i = t;
    @(posedge clk_i);
    #1 push_i = 1'b0;
  endtask

  task automatic set_load(input logic en, input logic [31:0] a, input logic [1:0] t);
    ld_lookup_i = en; ld_addr_i = a; ld_type_i = t;
    #1;
  endtask

  task automatic test_reset;
    #12;
    set_load(1'b1, 32'h0, T_BYTE);
    n_cmp++; if (empty_o !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", empty_o); end
    n_cmp++; if (full_o !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", full_o); end
    n_cmp++; if (drain_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_dvalid: got %b want 0", drain_valid_o); end
    n_cmp++; if ({drain_addr_o, drain_data_o, drain_type_o} !== 66'h0) begin n_err++;
      $display("FAIL reset_drain_bus: got %h/%h/%b want 0/0/00", drain_addr_o, drain_data_o, drain_type_o); end
    n_cmp++; if ({ld_hit_o, ld_conflict_o, ld_data_o} !== 34'h0) begin n_err++;
      $display("FAIL reset_lookup: got hit=%b conf=%b data=%h want 0/0/0", ld_hit_o, ld_conflict_o, ld_data_o); end
    @(negedge clk_i);
    rsn_i = 1'b1;
  endtask

  task automatic test_first_push;
    @(negedge clk_i);
    push_i = 1'b1; push_addr_i = 32'h0000_1000; push_data_i = 32'hDEAD_BEEF; push_type_i = T_WORD;
    set_load(1'b1, 32'h0000_1000, T_WORD);
    n_cmp++; if (drain_valid_o !== 1'b0 || ld_hit_o !== 1'b0) begin n_err++;
      $display("FAIL no_bypass: got dvalid=%b hit=%b want 0/0", drain_valid_o, ld_hit_o); end
    @(negedge clk_i);
    push_i = 1'b0;
    #1;
    n_cmp++; if (drain_valid_o !== 1'b1 || empty_o !== 1'b0) begin n_err++;
      $display("FAIL first_valid: got dvalid=%b empty=%b want 1/0", drain_valid_o, empty_o); end
    n_cmp++; if (drain_addr_o !== 32'h0000_1000 || drain_data_o !== 32'hDEAD_BEEF || drain_type_o !== T_WORD) begin n_err++;
      $display("FAIL first_drain: got %h/%h/%b want 00001000/deadbeef/10", drain_addr_o, drain_data_o, drain_type_o); end
    n_cmp++; if (ld_hit_o !== 1'b1 || ld_data_o !== 32'hDEAD_BEEF) begin n_err++;
      $display("FAIL first_fwd: got hit=%b data=%h want 1/deadbeef", ld_hit_o, ld_data_o); end
    drain_ready_i = 1'b1;
    @(negedge clk_i);
    drain_ready_i = 1'b0;
    set_load(1'b0, 32'h0, T_BYTE);
    n_cmp++; if (empty_o !== 1'b1) begin n_err++; $display("FAIL first_empty: got %b want 1", empty_o); end
  endtask

  task automatic test_fill;
    logic [31:0] exp_addr [4];
    exp_addr = '{32'h100, 32'h104, 32'h108, 32'h10C};
    for (int i = 0; i < 4; i++) push_one(exp_addr[i], 32'h0000_0050 + 32'(i), T_WORD);
    @(negedge clk_i);
    push_i = 1'b1; push_addr_i = 32'h0000_2000; push_data_i = 32'hFFFF_FFFF; push_type_i = T_WORD;
    #1;
    n_cmp++; if (full_o !== 1'b1) begin n_err++; $display("FAIL fill_full: got %b want 1", full_o); end
    @(negedge clk_i);
    push_i = 1'b0; drain_ready_i = 1'b1;
    #1;
    n_cmp++; if (full_o !== 1'b1) begin n_err++; $display("FAIL fill_still_full: got %b want 1", full_o); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (drain_valid_o !== 1'b1 || drain_addr_o !== exp_addr[k] || drain_data_o !== 32'h0000_0050 + 32'(k)) begin
        n_err++; $display("FAIL fill_order_%0d: got v=%b %h/%h want 1 %h/%h", k, drain_valid_o, drain_addr_o,
                          drain_data_o, exp_addr[k], 32'h0000_0050 + 32'(k)); end
      @(negedge clk_i);
    end
    drain_ready_i = 1'b0;
    #1;
    n_cmp++; if (empty_o !== 1'b1 || drain_valid_o !== 1'b0) begin n_err++;
      $display("FAIL fill_drained: got empty=%b dvalid=%b want 1/0", empty_o, drain_valid_o); end
  endtask

  task automatic test_back_to_back;
    push_one(32'h500, 32'hC0DE_0000, T_WORD);
    push_one(32'h504, 32'hC0DE_0001, T_WORD);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      push_i = 1'b1; push_addr_i = 32'h500 + 32'(4 * (c + 2)); push_data_i = 32'hC0DE_0000 + 32'(c + 2);
      push_type_i = T_WORD; drain_ready_i = 1'b1;
      #1;
      n_cmp++; if (drain_addr_o !== 32'h500 + 32'(4 * c) || drain_data_o !== 32'hC0DE_0000 + 32'(c)
                   || full_o !== 1'b0 || empty_o !== 1'b0) begin n_err++;
        $display("FAIL b2b_%0d: got %h/%h full=%b empty=%b want %h/%h 0/0", c, drain_addr_o, drain_data_o,
                 full_o, empty_o, 32'h500 + 32'(4 * c), 32'hC0DE_0000 + 32'(c)); end
    end
    @(negedge clk_i);
    push_i = 1'b0;
    #1;
    n_cmp++; if (drain_addr_o !== 32'h528) begin n_err++; $display("FAIL b2b_tail0: got %h want 00000528", drain_addr_o); end
    @(negedge clk_i);
    #1;
    n_cmp++; if (drain_addr_o !== 32'h52C) begin n_err++; $display("FAIL b2b_tail1: got %h want 0000052c", drain_addr_o); end
    @(negedge clk_i);
    drain_ready_i = 1'b0;
    #1;
    n_cmp++; if (empty_o !== 1'b1) begin n_err++; $display("FAIL b2b_empty: got %b want 1", empty_o); end
  endtask

  task automatic test_forward;
    push_one(32'h3001, 32'h0000_00AA, T_BYTE);
    push_one(32'h3000, 32'h1122_3344, T_WORD);
    @(negedge clk_i);
    set_load(1'b1, 32'h3000, T_WORD);
    n_cmp++; if (ld_hit_o !== 1'b1 || ld_conflict_o !== 1'b0 || ld_data_o !== 32'h1122_3344) begin n_err++;
      $display("FAIL fwd_word: got hit=%b conf=%b data=%h want 1/0/11223344", ld_hit_o, ld_conflict_o, ld_data_o); end
    set_load(1'b1, 32'h3001, T_BYTE);
    n_cmp++; if (ld_hit_o !== 1'b0 || ld_conflict_o !== 1'b1 || ld_data_o !== 32'h0) begin n_err++;
      $display("FAIL fwd_byte_conflict: got hit=%b conf=%b data=%h want 0/1/0", ld_hit_o, ld_conflict_o, ld_data_o); end
    set_load(1'b1, 32'h3004, T_WORD);
    n_cmp++; if (ld_hit_o !== 1'b0 || ld_conflict_o !== 1'b0) begin n_err++;
      $display("FAIL fwd_miss: got hit=%b conf=%b want 0/0", ld_hit_o, ld_conflict_o); end
    drain_ready_i = 1'b1;
    @(negedge clk_i);
    set_load(1'b1, 32'h3000, T_WORD);
    n_cmp++; if (drain_addr_o !== 32'h3000 || ld_hit_o !== 1'b1 || ld_data_o !== 32'h1122_3344) begin n_err++;
      $display("FAIL fwd_while_draining: got daddr=%h hit=%b data=%h want 00003000/1/11223344",
               drain_addr_o, ld_hit_o, ld_data_o); end
    @(negedge clk_i);
    drain_ready_i = 1'b0;
    set_load(1'b0, 32'h0, T_BYTE);
  endtask

  task automatic test_type_mismatch;
    push_one(32'h4000, 32'h0000_BEEF, T_HALF);
    @(negedge clk_i);
    set_load(1'b1, 32'h4000, T_WORD);
    n_cmp++; if (ld_hit_o !== 1'b0 || ld_conflict_o !== 1'b1 || ld_data_o !== 32'h0) begin n_err++;
      $display("FAIL type_conflict: got hit=%b conf=%b data=%h want 0/1/0", ld_hit_o, ld_conflict_o, ld_data_o); end
    set_load(1'b1, 32'h4000, T_HALF);
    n_cmp++; if (ld_hit_o !== 1'b1 || ld_data_o !== 32'h0000_BEEF) begin n_err++;
      $display("FAIL type_half_hit: got hit=%b data=%h want 1/0000beef", ld_hit_o, ld_data_o); end
    set_load(1'b0, 32'h4000, T_HALF);
    n_cmp++; if ({ld_hit_o, ld_conflict_o, ld_data_o} !== 34'h0) begin n_err++;
      $display("FAIL lookup_disabled: got hit=%b conf=%b data=%h want 0/0/0", ld_hit_o, ld_conflict_o, ld_data_o); end
    drain_ready_i = 1'b1;
    @(negedge clk_i);
    drain_ready_i = 1'b0;
  endtask

  task automatic test_async_reset;
    push_one(32'h600, 32'h1, T_WORD);
    push_one(32'h604, 32'h2, T_WORD);
    push_one(32'h608, 32'h3, T_WORD);
    @(negedge clk_i);
    drain_ready_i = 1'b1;
    #1;
    n_cmp++; if (drain_valid_o !== 1'b1 || drain_addr_o !== 32'h600) begin n_err++;
      $display("FAIL arst_pre: got v=%b addr=%h want 1/00000600", drain_valid_o, drain_addr_o); end
    #1 rsn_i = 1'b0;
    #1;
    n_cmp++; if (empty_o !== 1'b1 || drain_valid_o !== 1'b0 || drain_addr_o !== 32'h0) begin n_err++;
      $display("FAIL arst_immediate: got empty=%b v=%b addr=%h want 1/0/0", empty_o, drain_valid_o, drain_addr_o); end
    #1 rsn_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_i);
      set_load(1'b1, 32'h604, T_WORD);
      n_cmp++; if (drain_valid_o !== 1'b0 || empty_o !== 1'b1 || ld_hit_o !== 1'b0) begin n_err++;
        $display("FAIL arst_after_%0d: got v=%b empty=%b hit=%b want 0/1/0", k, drain_valid_o, empty_o, ld_hit_o); end
    end
    drain_ready_i = 1'b0;
  endtask

  initial begin
    rsn_i = 1'b0; push_i = 1'b0; push_addr_i = '0; push_data_i = '0; push_type_i = T_BYTE;
    ld_lookup_i = 1'b0; ld_addr_i = '0; ld_type_i = T_BYTE; drain_ready_i = 1'b0;
    test_reset();
    test_first_push();
    test_fill();
    test_back_to_back();
    test_forward();
    test_type_mismatch();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
